// File: rtl/camera_pkg.sv
// Shared types and exposure-range defaults for the camera sequencer and the
// exposure-time control register.
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXPOSE,
        R0,
        R1,
        R2,
        R3,
        R4,
        R5
    } cam_state_t;

    localparam int CAM_EX_MIN   = 2;
    localparam int CAM_EX_MAX   = 30;
    localparam int CAM_EX_RESET = 15;
    localparam int READOUT_LEN  = 6;

    typedef struct packed {
        logic erase;
        logic expose;
        logic nre_1;
        logic nre_2;
        logic adc;
        logic busy;
        logic frame_done;
    } cam_out_t;

endpackage

// File: rtl/exp_down_counter.sv
// Loadable down-counter timing the exposure; last flags the final exposure cycle.
module exp_down_counter
    import camera_pkg::*;
#(
    parameter int EX_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            en,
    input  logic [EX_W-1:0] load_val,
    output logic            last
);

    logic [EX_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == EX_W'(1));

endmodule

// File: rtl/camera_seq_ctrl.sv
// Capture sequencer: erase, timed exposure, two-row readout, back to erase.
// Outputs are registered from the decoded next state so they move with the state.
module camera_seq_ctrl
    import camera_pkg::*;
#(
    parameter int EX_W   = 5,
    parameter int EX_MIN = CAM_EX_MIN,
    parameter int EX_MAX = CAM_EX_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic [EX_W-1:0] ex_time,
    output logic            erase,
    output logic            expose,
    output logic            nre_1,
    output logic            nre_2,
    output logic            adc,
    output logic            busy,
    output logic            frame_done
);

    cam_state_t state, next_state;
    cam_out_t   out_d, out_q;
    logic       cnt_load, cnt_en, cnt_last;

    function automatic logic [EX_W-1:0] clamp_ex(input logic [EX_W-1:0] t);
        if (int'(t) < EX_MIN) begin
            return EX_W'(EX_MIN);
        end else if (int'(t) > EX_MAX) begin
            return EX_W'(EX_MAX);
        end
        return t;
    endfunction

    // Clamped exposure is latched only on the IDLE->EXPOSE edge
    assign cnt_load = (state == IDLE) && init;
    assign cnt_en   = (state == EXPOSE);

    exp_down_counter #(
        .EX_W(EX_W)
    ) u_exp_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .en      (cnt_en),
        .load_val(clamp_ex(ex_time)),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (init) next_state = EXPOSE;
            EXPOSE:  if (cnt_last) next_state = R0;
            R0:      next_state = R1;
            R1:      next_state = R2;
            R2:      next_state = R3;
            R3:      next_state = R4;
            R4:      next_state = R5;
            R5:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decode of the state being entered; captured on the same edge as the state
    always_comb begin
        out_d = '{erase: 1'b0, expose: 1'b0, nre_1: 1'b1, nre_2: 1'b1,
                  adc: 1'b0, busy: 1'b1, frame_done: 1'b0};
        unique case (next_state)
            IDLE: begin
                out_d.erase = 1'b1;
                out_d.busy  = 1'b0;
            end
            EXPOSE: out_d.expose = 1'b1;
            R0:     out_d.nre_1 = 1'b0;
            R1: begin
                out_d.nre_1 = 1'b0;
                out_d.adc   = 1'b1;
            end
            R2:     ;
            R3:     out_d.nre_2 = 1'b0;
            R4: begin
                out_d.nre_2 = 1'b0;
                out_d.adc   = 1'b1;
            end
            R5:     out_d.frame_done = 1'b1;
            default: begin
                out_d.erase = 1'b1;
                out_d.busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '{erase: 1'b1, expose: 1'b0, nre_1: 1'b1, nre_2: 1'b1,
                       adc: 1'b0, busy: 1'b0, frame_done: 1'b0};
        end else begin
            out_q <= out_d;
        end
    end

    assign erase      = out_q.erase;
    assign expose     = out_q.expose;
    assign nre_1      = out_q.nre_1;
    assign nre_2      = out_q.nre_2;
    assign adc        = out_q.adc;
    assign busy       = out_q.busy;
    assign frame_done = out_q.frame_done;

endmodule

// File: tb/tb_camera_seq_ctrl.sv
// Directed bench for camera_seq_ctrl with per-cycle output vector checks.
module tb_camera_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [4:0] ex_time;
    logic       erase, expose, nre_1, nre_2, adc, busy, frame_done;

    int  total = 0;
    int  bad   = 0;
    bit  checks_on = 1'b0;

    // {erase, expose, nre_1, nre_2, adc, busy, frame_done}
    localparam logic [6:0] V_IDLE = 7'b1011000;
    localparam logic [6:0] V_EXP  = 7'b0111010;

    camera_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .ex_time   (ex_time),
        .erase     (erase),
        .expose    (expose),
        .nre_1     (nre_1),
        .nre_2     (nre_2),
        .adc       (adc),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {erase, expose, nre_1, nre_2, adc, busy, frame_done};
    endfunction

    function automatic logic [6:0] readout_vec(input int r);
        case (r)
            0:       return 7'b0001010;
            1:       return 7'b0001110;
            2:       return 7'b0011010;
            3:       return 7'b0010010;
            4:       return 7'b0010110;
            default: return 7'b0011011;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checks_on) begin
            chk("inv_nre_both_low", 32'(!nre_1 && !nre_2), 32'd0);
            chk("inv_adc_one_row", 32'(adc && !(nre_1 ^ nre_2)), 32'd0);
            chk("inv_expose_erase", 32'(expose && erase), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            chk($sformatf("idle%0d", i), 32'(obs()), 32'(V_IDLE));
        end
    endtask

    // Starts from an IDLE cycle; n is the hand-clamped exposure length.
    task automatic frame(input int ex, input int n, input bit hold, input bit mess,
                         input int abort_at);
        ex_time = 5'(ex);
        init    = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            tick();
            if (c == 0 && !hold) init = 1'b0;
            if (mess) begin
                if (c == 3) ex_time = 5'd25;
                if (c == 4 || c == n + 2) init = 1'b1;
                if (c == 5 || c == n + 3) init = 1'b0;
            end
            chk($sformatf("ex%0d_c%0d", ex, c), 32'(obs()),
                32'((c < n) ? V_EXP : readout_vec(c - n)));
            if (c == abort_at) begin
                reset = 1'b1;
                tick();
                chk($sformatf("ex%0d_rst_c%0d", ex, c), 32'(obs()), 32'(V_IDLE));
                reset = 1'b0;
                return;
            end
        end
        tick();
        chk($sformatf("ex%0d_end", ex), 32'(obs()), 32'(V_IDLE));
    endtask

    initial begin
        reset   = 1'b1;
        init    = 1'b0;
        ex_time = 5'd0;
        tick();
        tick();
        chk("reset_state", 32'(obs()), 32'(V_IDLE));
        checks_on = 1'b1;
        reset = 1'b0;
        idle_cycles(2);

        frame(15, 15, 1'b0, 1'b0, -1);
        idle_cycles(1);
        frame(0, 2, 1'b0, 1'b0, -1);
        idle_cycles(1);
        frame(31, 30, 1'b0, 1'b0, -1);
        idle_cycles(1);
        frame(1, 2, 1'b0, 1'b0, -1);
        idle_cycles(1);

        frame(10, 10, 1'b0, 1'b1, -1);
        idle_cycles(2);

        frame(10, 10, 1'b0, 1'b0, 5);
        idle_cycles(1);
        frame(12, 12, 1'b0, 1'b0, -1);
        idle_cycles(1);
        frame(7, 7, 1'b0, 1'b0, 7 + 3);
        idle_cycles(1);
        frame(7, 7, 1'b0, 1'b0, -1);
        idle_cycles(1);

        frame(2, 2, 1'b1, 1'b0, -1);
        frame(2, 2, 1'b1, 1'b0, -1);
        frame(2, 2, 1'b0, 1'b0, -1);
        idle_cycles(2);

        checks_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
